// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtractive GCD sequencer.
// Optional timeout limit is enabled with the GCD_TIMEOUT_EN macro.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  localparam logic SEL_EXT  = 1'b0;
  localparam logic SEL_DIFF = 1'b1;

  localparam int unsigned GCD_ITER_W   = 8;
  localparam int unsigned GCD_MAX_ITER = 200;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating subtraction counter with synchronous clear and a compare against the
// timeout limit.
module gcd_iter_counter #(
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              incr,
  output logic [ITER_W-1:0] count,
  output logic              hit_max
);

  localparam logic [ITER_W-1:0] MaxCount = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] AllOnes  = {ITER_W{1'b1}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != AllOnes)) begin
      count <= count + 1'b1;
    end
  end

  assign hit_max = (count == MaxCount);

endmodule

// File: rtl/gcd_sequencer.sv
// Control FSM for the subtractive GCD datapath with request/response handshakes.
// Define GCD_TIMEOUT_EN to abort operations after MAX_ITER subtractions.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned ITER_W   = GCD_ITER_W,
  parameter int unsigned MAX_ITER = GCD_MAX_ITER
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_error,
  output logic [ITER_W-1:0] iter_count,
  input  logic              x_lt_y,
  input  logic              x_ne_y,
  output logic              x_sel,
  output logic              y_sel,
  output logic              x_en,
  output logic              y_en,
  output logic              output_en
);

  gcd_state_e state_q, state_d;
  logic       cnt_clear, cnt_incr, hit_max, timeout_hit;

  gcd_iter_counter #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .incr    (cnt_incr),
    .count   (iter_count),
    .hit_max (hit_max)
  );

`ifdef GCD_TIMEOUT_EN
  logic err_q;

  assign timeout_hit = (state_q == RUN) && hit_max && x_ne_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end else if ((state_q == DONE) && out_ready) begin
      err_q <= 1'b0;
    end
  end

  assign out_error = err_q;
`else
  logic unused_hit_max;

  assign unused_hit_max = hit_max;
  assign timeout_hit    = 1'b0;
  assign out_error      = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = RUN;
          cnt_clear = 1'b1;
        end
      end
      RUN: begin
        if (timeout_hit || !x_ne_y) begin
          state_d = DONE;
        end else begin
          cnt_incr = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so every output reads 0 in reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    x_sel     = SEL_EXT;
    y_sel     = SEL_EXT;
    x_en      = 1'b0;
    y_en      = 1'b0;
    output_en = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            x_en = 1'b1;
            y_en = 1'b1;
          end
        end
        RUN: begin
          if (timeout_hit) begin
            output_en = 1'b0;
          end else if (!x_ne_y) begin
            output_en = 1'b1;
          end else if (x_lt_y) begin
            y_sel = SEL_DIFF;
            y_en  = 1'b1;
          end else begin
            x_sel = SEL_DIFF;
            x_en  = 1'b1;
          end
        end
        DONE: out_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a behavioural 32-bit datapath, a table of directed vectors,
// handshake corner cases and random operands checked against a Euclid-based model.
module tb_gcd_sequencer;

  localparam int unsigned IterW   = 8;
  localparam int unsigned MaxIter = 200;
  localparam int          LatLim  = 400;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, out_valid, out_ready, out_error;
  logic [IterW-1:0] iter_count;
  logic             x_lt_y, x_ne_y, x_sel, y_sel, x_en, y_en, output_en;
  logic [31:0]      op_x, op_y, dx, dy, dout;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_out;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    int          exp_iter;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  gcd_sequencer #(
    .ITER_W   (IterW),
    .MAX_ITER (MaxIter)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_error  (out_error),
    .iter_count (iter_count),
    .x_lt_y     (x_lt_y),
    .x_ne_y     (x_ne_y),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .x_en       (x_en),
    .y_en       (y_en),
    .output_en  (output_en)
  );

  always #5 clock = ~clock;

  // Datapath stand-in driven by the sequencer's controls.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dx   <= '0;
      dy   <= '0;
      dout <= '0;
    end else begin
      if (x_en) dx <= x_sel ? dx - dy : op_x;
      if (y_en) dy <= y_sel ? dy - dx : op_y;
      if (output_en) dout <= dx;
    end
  end

  assign x_lt_y = dx < dy;
  assign x_ne_y = dx != dy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // While a result is offered, the datapath must be frozen and no request accepted.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      check("done_quiet", {28'd0, x_en, y_en, output_en, in_ready}, 32'd0);
    end
    if (!reset && !in_ready && x_en && y_en) begin
      check("run_one_enable", 32'd1, 32'd0);
    end
  end

  // Subtraction count from Euclid: sum of quotients minus one; gcd is the final divisor.
  function automatic int model_subs(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    int n = 0;
    if (a == 0 || b == 0) return 0;
    while (b != 0) begin
      n += int'(a / b);
      t = a % b;
      a = b;
      b = t;
    end
    return n - 1;
  endfunction

  function automatic logic [31:0] model_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int sat(input int n);
    return (n > int'((1 << IterW) - 1)) ? int'((1 << IterW) - 1) : n;
  endfunction

  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_out, input int exp_iter,
                                input int exp_lat, input logic exp_err, input string name);
    int lat = 0;
    int w = 0;
    logic got = 1'b0;
    while (!in_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    op_x     = a;
    op_y     = b;
    in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_load"}, {28'd0, x_en, y_en, x_sel, y_sel}, 32'b1100);
    while (!got && lat < LatLim) begin
      @(negedge clock);
      lat++;
      in_valid = 1'b0;
      got = out_valid;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_out"}, dout, exp_out);
    check({name, "_iter"}, 32'(iter_count), exp_iter);
    check({name, "_err"}, {31'd0, out_error}, {31'd0, exp_err});
  endtask

  task automatic finish_op(input string name);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({name, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    start_and_wait(v.a, v.b, v.exp_out, v.exp_iter, v.exp_lat, 1'b0, name);
    last_out = v.exp_out;
    finish_op(name);
  endtask

  initial begin
    vec_t v;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_x      = '0;
    op_y      = '0;
    last_out  = '0;

    vecs.push_back('{32'd12, 32'd18, 32'd6, 2, 4});
    vecs.push_back('{32'd7, 32'd7, 32'd7, 0, 2});
    vecs.push_back('{32'd0, 32'd0, 32'd0, 0, 2});
    vecs.push_back('{32'd100, 32'd75, 32'd25, 3, 5});
    vecs.push_back('{32'd1, 32'd13, 32'd1, 12, 14});
`ifndef GCD_TIMEOUT_EN
    vecs.push_back('{32'd300, 32'd1, 32'd1, 255, 301});
`endif

    repeat (2) @(negedge clock);
    check("reset_outputs", {iter_count, 17'd0, in_ready, out_valid, out_error, x_en, y_en,
                            output_en, x_sel}, 32'd0);
    reset = 1'b0;
    #1;
    check("reset_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: result held while a second request is presented.
    start_and_wait(32'd21, 32'd6, 32'd3, 4, 6, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      op_x     = 32'd50;
      op_y     = 32'd10;
      in_valid = 1'b1;
      @(negedge clock);
      check("bp_hold", {out_valid, in_ready, out_error, 21'd0, iter_count}, {3'b100, 29'd4});
      check("bp_out", dout, 32'd3);
    end
    in_valid = 1'b0;
    last_out = 32'd3;
    finish_op("bp");
    v = '{32'd50, 32'd10, 32'd10, 4, 6};
    run_vec(v, "bp_next");

`ifdef GCD_TIMEOUT_EN
    start_and_wait(32'd0, 32'd5, last_out, int'(MaxIter), int'(MaxIter) + 2, 1'b1, "timeout");
    finish_op("timeout");
    check("timeout_err_clear", {31'd0, out_error}, 32'd0);
`endif

    // Reset in the middle of a long run.
    op_x     = 32'd1000;
    op_y     = 32'd3;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (20) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {iter_count, 17'd0, in_ready, out_valid, out_error, x_en, y_en,
                               output_en, x_sel}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset_idle", {iter_count, 22'd0, in_ready, out_valid}, 32'b10);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        seen += int'(out_valid);
      end
      check("midreset_no_result", seen, 0);
    end
    v = '{32'd9, 32'd6, 32'd3, 2, 4};
    run_vec(v, "after_reset");

    for (int i = 0; i < 30; i++) begin
      v.a        = $urandom_range(150, 1);
      v.b        = $urandom_range(150, 1);
      v.exp_out  = model_gcd(v.a, v.b);
      v.exp_iter = sat(model_subs(v.a, v.b));
      v.exp_lat  = model_subs(v.a, v.b) + 2;
      run_vec(v, $sformatf("rand%0d", i));
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
